// File: rtl/instr_loader_if.sv
// Loader-side bus bundle for instr_loader.
// It carries the byte-stream handshake, the instruction-memory write port and
// the CPU reset/status outputs.
// The loader uses the slave modport. The driving environment uses master.
interface instr_loader_if #(
    parameter int WORD_W = 19,
    parameter int ADDR_W = 5
);
    logic              load_req;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_wdata;
    logic              cpu_reset;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   words_loaded;

    modport master (
        output load_req, in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata,
        input  cpu_reset, load_done, load_err, words_loaded
    );

    modport slave (
        input  load_req, in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata,
        output cpu_reset, load_done, load_err, words_loaded
    );
endinterface

// File: rtl/instr_loader.sv
// Boot-time program loader for the CPU's instruction memory.
//
// Stream layout: a count byte N (1..DEPTH), then 3 bytes per word, sent
// big-endian. The hi byte carries word[18:16] in bits[2:0], and its upper bits
// must be zero. Addresses N..DEPTH-1 are then padded with FILL_WORD. The CPU is
// held in reset until a complete image is in memory.
//
// Optional feature macro: INSTR_LOADER_CHECKSUM_EN. When it is defined, the
// stream carries one more byte after the last word. That byte is the XOR of
// all payload bytes, and it is checked before padding starts.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | after reset, waiting for load_req; CPU held in reset
// COUNT   | waiting for the word-count byte
// HI      | waiting for the hi byte of the next word
// MID     | waiting for the mid byte
// LO      | waiting for the lo byte
// WR      | one-cycle write of the assembled word; no byte accepted
// CHECK   | waiting for the checksum byte (checksum build only)
// FILL    | writing FILL_WORD to each remaining address
// RUN     | image complete; CPU released
// ERROR   | malformed stream; CPU held in reset; memory left partial
module instr_loader #(
    parameter int                WORD_W    = 19,
    parameter int                DEPTH     = 32,
    parameter int                ADDR_W    = 5,
    parameter logic [WORD_W-1:0] FILL_WORD = 19'h00000
) (
    input logic            clk,
    input logic            reset,
    instr_loader_if.slave  bus
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int HI_W  = WORD_W - 16;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_COUNT = 4'd1;
    localparam logic [3:0] S_HI    = 4'd2;
    localparam logic [3:0] S_MID   = 4'd3;
    localparam logic [3:0] S_LO    = 4'd4;
    localparam logic [3:0] S_WR    = 4'd5;
    localparam logic [3:0] S_FILL  = 4'd6;
    localparam logic [3:0] S_RUN   = 4'd7;
    localparam logic [3:0] S_ERROR = 4'd8;
`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam logic [3:0] S_CHECK = 4'd9;
`endif

    logic [3:0]        state_q, state_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [HI_W-1:0]   hi_q, hi_d;
    logic [7:0]        mid_q, mid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  words_loaded_q, words_loaded_d;
    logic              in_ready_q, in_ready_d;
    logic              imem_we_q, imem_we_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              load_done_q, load_done_d;
    logic              load_err_q, load_err_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic              xfer;
    logic              image_done;
    logic [CNT_W-1:0]  words_next;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d        = state_q;
        n_d            = n_q;
        hi_d           = hi_q;
        mid_d          = mid_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        words_loaded_d = words_loaded_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
        csum_d         = csum_q;
`endif
        image_done     = 1'b0;
        xfer           = bus.in_valid && in_ready_q;
        words_next     = words_loaded_q + CNT_W'(1);

        case (state_q)
            S_IDLE, S_RUN, S_ERROR: begin
                if (bus.load_req) begin
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                if (xfer) begin
                    if (bus.in_data == 8'd0 || bus.in_data > 8'(DEPTH)) begin
                        state_d = S_ERROR;
                    end else begin
                        n_d            = bus.in_data[CNT_W-1:0];
                        addr_d         = '0;
                        words_loaded_d = '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                        csum_d         = 8'h00;
`endif
                        state_d        = S_HI;
                    end
                end
            end
            S_HI: begin
                if (xfer) begin
                    if (|bus.in_data[7:HI_W]) begin
                        state_d = S_ERROR;
                    end else begin
                        hi_d    = bus.in_data[HI_W-1:0];
`ifdef INSTR_LOADER_CHECKSUM_EN
                        csum_d  = csum_q ^ bus.in_data;
`endif
                        state_d = S_MID;
                    end
                end
            end
            S_MID: begin
                if (xfer) begin
                    mid_d   = bus.in_data;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ bus.in_data;
`endif
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (xfer) begin
                    wdata_d = {hi_q, mid_q, bus.in_data};
`ifdef INSTR_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ bus.in_data;
`endif
                    state_d = S_WR;
                end
            end
            S_WR: begin
                words_loaded_d = words_next;
                if (words_next == n_q) begin
                    // The last image word keeps addr_q, so an N = DEPTH image
                    // never wraps the address back to zero.
`ifdef INSTR_LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    image_done = 1'b1;
`endif
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_HI;
                end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (xfer) begin
                    if (bus.in_data == csum_q) begin
                        image_done = 1'b1;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
`endif
            S_FILL: begin
                if (addr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = S_RUN;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A full image skips padding and releases the CPU right after its last write.
        if (image_done) begin
            if (n_q == CNT_W'(DEPTH)) begin
                state_d = S_RUN;
            end else begin
                state_d = S_FILL;
                addr_d  = n_q[ADDR_W-1:0];
                wdata_d = FILL_WORD;
            end
        end

        // Outputs are registered copies of what the next state implies.
        in_ready_d  = (state_d == S_COUNT) || (state_d == S_HI) ||
                      (state_d == S_MID)   || (state_d == S_LO);
`ifdef INSTR_LOADER_CHECKSUM_EN
        if (state_d == S_CHECK) begin
            in_ready_d = 1'b1;
        end
`endif
        imem_we_d   = (state_d == S_WR) || (state_d == S_FILL);
        cpu_reset_d = (state_d != S_RUN);
        load_done_d = (state_d == S_RUN);
        load_err_d  = (state_d == S_ERROR);
    end

    // State and output registers. Asynchronous reset parks the block in IDLE
    // with the CPU held in reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            n_q            <= '0;
            hi_q           <= '0;
            mid_q          <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            words_loaded_q <= '0;
            in_ready_q     <= 1'b0;
            imem_we_q      <= 1'b0;
            cpu_reset_q    <= 1'b1;
            load_done_q    <= 1'b0;
            load_err_q     <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum_q         <= 8'h00;
`endif
        end else begin
            state_q        <= state_d;
            n_q            <= n_d;
            hi_q           <= hi_d;
            mid_q          <= mid_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            words_loaded_q <= words_loaded_d;
            in_ready_q     <= in_ready_d;
            imem_we_q      <= imem_we_d;
            cpu_reset_q    <= cpu_reset_d;
            load_done_q    <= load_done_d;
            load_err_q     <= load_err_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum_q         <= csum_d;
`endif
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.imem_we      = imem_we_q;
    assign bus.imem_addr    = addr_q;
    assign bus.imem_wdata   = wdata_q;
    assign bus.cpu_reset    = cpu_reset_q;
    assign bus.load_done    = load_done_q;
    assign bus.load_err     = load_err_q;
    assign bus.words_loaded = words_loaded_q;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader.
// It runs fixed vectors, reset corner cases and random loads, and checks each
// load against a stream-parsing model.
// Build with +define+INSTR_LOADER_CHECKSUM_EN to exercise the checksum variant.
module tb_instr_loader;

    localparam int          DEPTH = 32;
    localparam logic [18:0] FILL  = 19'h00000;

    typedef logic [23:0] wr_t;  // {addr[4:0], data[18:0]}

    typedef struct {
        logic [63:0] bytes;     // stream bytes, left-aligned, first byte in [63:56]
        int          len;
        bit          add_csum;
        bit          toggle;
        bit          exp_done;
        int          exp_writes;
        int          exp_wl;    // -1: not checked
        logic [18:0] exp_w0;
        logic [18:0] exp_w1;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    instr_loader_if bus ();

    instr_loader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   n_pass = 0;
    int   n_total = 0;
    logic [7:0] stream_q[$];
    wr_t  wr_q[$];
    wr_t  exp_q[$];
    vec_t vecs [8];
    int   n_vecs;
    bit   m_done;
    int   m_cons;
    int   m_wl;
    bit   ok;
    logic [7:0] x8;

    // Record every write seen on the memory port.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) wr_q.push_back({bus.imem_addr, bus.imem_wdata});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap, output bit acc);
        acc = 1'b0;
        if (gap) @(negedge clk);
        for (int c = 0; c < 64 && !acc; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = b;
            if (bus.in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                acc = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_load_req();
        @(negedge clk);
        bus.load_req = 1'b1;
        @(negedge clk);
        bus.load_req = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        for (int c = 0; c < 200 && !(bus.load_done === 1'b1 || bus.load_err === 1'b1); c++)
            @(negedge clk);
        chk({tag, "_end"}, 32'(bus.load_done | bus.load_err), 32'd1);
    endtask

    task automatic do_load(input string tag, input bit toggle);
        bit all_ok;
        bit acc;
        all_ok = 1'b1;
        wr_q.delete();
        pulse_load_req();
        foreach (stream_q[i]) begin
            if (all_ok) begin
                send_byte(stream_q[i], toggle, acc);
                if (!acc) all_ok = 1'b0;
            end
        end
        chk({tag, "_accept"}, 32'(all_ok), 32'd1);
        wait_end(tag);
    endtask

    // Reference: parse the stream by its format rules to get the outcome and
    // the exact sequence of memory writes.
    task automatic model(output bit done, output int consumed, output int wl);
        int n;
        logic [7:0] hi, mid, lo, x;
        exp_q.delete();
        done = 1'b0; wl = -1; consumed = 1; x = 8'h00;
        n = int'(stream_q[0]);
        if (n == 0 || n > DEPTH) return;
        wl = 0;
        for (int w = 0; w < n; w++) begin
            hi = stream_q[1+3*w];
            consumed = 2 + 3*w;
            if (hi[7:3] != 5'd0) return;
            mid = stream_q[2+3*w];
            lo  = stream_q[3+3*w];
            consumed = 4 + 3*w;
            x = x ^ hi ^ mid ^ lo;
            exp_q.push_back({5'(w), hi[2:0], mid, lo});
            wl = w + 1;
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        consumed++;
        if (stream_q[consumed-1] != x) return;
`endif
        for (int a = n; a < DEPTH; a++) exp_q.push_back({5'(a), FILL});
        done = 1'b1;
    endtask

    task automatic gen_random(input int n_force, input int kind);
        int n;
        int bad_w;
        logic [7:0] hi, mid, lo, x;
        stream_q.delete();
        n = (n_force > 0) ? n_force : int'($urandom_range(1, DEPTH));
        if (kind == 0) stream_q.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(33, 255)));
        else stream_q.push_back(8'(n));
        bad_w = int'($urandom_range(0, n - 1));
        x = 8'h00;
        for (int w = 0; w < n; w++) begin
            hi = 8'($urandom_range(0, 7));
            if (kind == 1 && w == bad_w) hi = hi | 8'($urandom_range(1, 31) << 3);
            mid = 8'($urandom);
            lo  = 8'($urandom);
            x = x ^ hi ^ mid ^ lo;
            stream_q.push_back(hi);
            stream_q.push_back(mid);
            stream_q.push_back(lo);
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        stream_q.push_back((kind == 2) ? (x ^ 8'($urandom_range(1, 255))) : x);
`endif
    endtask

    task automatic run_modelled(input string tag, input bit toggle);
        bit done;
        int cons;
        int wl;
        int bad;
        model(done, cons, wl);
        while (stream_q.size() > cons) void'(stream_q.pop_back());
        do_load(tag, toggle);
        chk({tag, "_done"}, 32'(bus.load_done), 32'(done));
        chk({tag, "_err"}, 32'(bus.load_err), 32'(!done));
        chk({tag, "_cpu_reset"}, 32'(bus.cpu_reset), 32'(!done));
        if (wl >= 0) chk({tag, "_words_loaded"}, 32'(bus.words_loaded), 32'(wl));
        chk({tag, "_nwrites"}, 32'(wr_q.size()), 32'(exp_q.size()));
        bad = 0;
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
            if (wr_q[i] !== exp_q[i]) bad++;
        chk({tag, "_write_mismatches"}, 32'(bad), 32'd0);
    endtask

    initial begin
        bus.load_req = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Reset values.
        #12;
        chk("rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_imem_we", 32'(bus.imem_we), 32'd0);
        chk("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
        chk("rst_imem_wdata", 32'(bus.imem_wdata), 32'd0);
        chk("rst_load_done", 32'(bus.load_done), 32'd0);
        chk("rst_load_err", 32'(bus.load_err), 32'd0);
        chk("rst_words_loaded", 32'(bus.words_loaded), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Fixed vectors.
        vecs[0] = '{64'h02_01_23_45_06_78_9A_00, 7, 1'b1, 1'b0, 1'b1, 32, 2, 19'h12345, 19'h6789A};
        vecs[1] = '{64'h00_00_00_00_00_00_00_00, 1, 1'b0, 1'b0, 1'b0, 0, -1, 19'h0, 19'h0};
        vecs[2] = '{64'h21_00_00_00_00_00_00_00, 1, 1'b0, 1'b0, 1'b0, 0, -1, 19'h0, 19'h0};
        vecs[3] = '{64'h01_08_00_00_00_00_00_00, 2, 1'b0, 1'b0, 1'b0, 0, 0, 19'h0, 19'h0};
        vecs[4] = '{64'h02_01_23_45_F0_00_00_00, 5, 1'b0, 1'b1, 1'b0, 1, 1, 19'h12345, 19'h0};
        vecs[5] = '{64'h01_07_FF_FF_00_00_00_00, 4, 1'b1, 1'b1, 1'b1, 32, 1, 19'h7FFFF, FILL};
        n_vecs = 6;
`ifdef INSTR_LOADER_CHECKSUM_EN
        vecs[6] = '{64'h01_00_00_0F_0F_00_00_00, 5, 1'b0, 1'b0, 1'b1, 32, 1, 19'h0000F, FILL};
        vecs[7] = '{64'h01_00_00_0F_0E_00_00_00, 5, 1'b0, 1'b0, 1'b0, 1, 1, 19'h0000F, 19'h0};
        n_vecs = 8;
`endif
        for (int i = 0; i < n_vecs; i++) begin
            stream_q.delete();
            for (int k = 0; k < vecs[i].len; k++) stream_q.push_back(vecs[i].bytes[63-8*k -: 8]);
`ifdef INSTR_LOADER_CHECKSUM_EN
            if (vecs[i].add_csum) begin
                x8 = 8'h00;
                for (int k = 1; k < vecs[i].len; k++) x8 = x8 ^ vecs[i].bytes[63-8*k -: 8];
                stream_q.push_back(x8);
            end
`endif
            do_load($sformatf("v%0d", i), vecs[i].toggle);
            chk($sformatf("v%0d_done", i), 32'(bus.load_done), 32'(vecs[i].exp_done));
            chk($sformatf("v%0d_err", i), 32'(bus.load_err), 32'(!vecs[i].exp_done));
            chk($sformatf("v%0d_cpu_reset", i), 32'(bus.cpu_reset), 32'(!vecs[i].exp_done));
            chk($sformatf("v%0d_nwrites", i), 32'(wr_q.size()), 32'(vecs[i].exp_writes));
            if (vecs[i].exp_wl >= 0)
                chk($sformatf("v%0d_words_loaded", i), 32'(bus.words_loaded), 32'(vecs[i].exp_wl));
            if (vecs[i].exp_writes >= 1 && wr_q.size() >= 1)
                chk($sformatf("v%0d_write0", i), 32'(wr_q[0]), 32'({5'd0, vecs[i].exp_w0}));
            if (vecs[i].exp_writes >= 2 && wr_q.size() >= 2)
                chk($sformatf("v%0d_write1", i), 32'(wr_q[1]), 32'({5'd1, vecs[i].exp_w1}));
            if (vecs[i].exp_writes == DEPTH && wr_q.size() == DEPTH)
                chk($sformatf("v%0d_last_write", i), 32'(wr_q[DEPTH-1]), 32'({5'd31, FILL}));
        end

        // Reload from RUN: cpu_reset rises as COUNT is entered, and a
        // load_req during the load is ignored.
        gen_random(3, 3);
        run_modelled("pre_reload", 1'b0);
        wr_q.delete();
        @(negedge clk);
        bus.load_req = 1'b1;
        @(posedge clk);
        #1;
        chk("reload_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        chk("reload_load_done", 32'(bus.load_done), 32'd0);
        chk("reload_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.load_req = 1'b0;
        send_byte(8'h01, 1'b0, ok);
        pulse_load_req();
        send_byte(8'h00, 1'b0, ok);
        send_byte(8'h00, 1'b0, ok);
        send_byte(8'h01, 1'b0, ok);
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(8'h01, 1'b0, ok);
`endif
        wait_end("midreq");
        chk("midreq_done", 32'(bus.load_done), 32'd1);
        chk("midreq_words_loaded", 32'(bus.words_loaded), 32'd1);
        chk("midreq_nwrites", 32'(wr_q.size()), 32'd32);

        // Reset asserted while a byte is expected.
        pulse_load_req();
        send_byte(8'h02, 1'b0, ok);
        send_byte(8'h01, 1'b0, ok);
        @(negedge clk);
        chk("midrst_ready_before", 32'(bus.in_ready), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("midrst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("midrst_imem_we", 32'(bus.imem_we), 32'd0);
        chk("midrst_load_done", 32'(bus.load_done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h01;
        repeat (3) @(negedge clk);
        chk("midrst_idle_ready", 32'(bus.in_ready), 32'd0);
        chk("midrst_words_loaded", 32'(bus.words_loaded), 32'd0);
        bus.in_valid = 1'b0;

        // A load_req held while reset is low is lost.
        @(negedge clk);
        reset = 1'b0;
        bus.load_req = 1'b1;
        @(negedge clk);
        bus.load_req = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rstreq_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rstreq_cpu_reset", 32'(bus.cpu_reset), 32'd1);

        // Reset during padding.
        pulse_load_req();
        send_byte(8'h01, 1'b0, ok);
        send_byte(8'h00, 1'b0, ok);
        send_byte(8'h00, 1'b0, ok);
        send_byte(8'h0F, 1'b0, ok);
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(8'h0F, 1'b0, ok);
`endif
        for (int c = 0; c < 60 && !(bus.imem_we === 1'b1 && bus.imem_addr == 5'd5); c++) @(negedge clk);
        chk("fillrst_seen", 32'(bus.imem_we === 1'b1 && bus.imem_addr == 5'd5), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("fillrst_imem_we", 32'(bus.imem_we), 32'd0);
        chk("fillrst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        chk("fillrst_no_done", 32'(bus.load_done), 32'd0);

        // Full 32-word image, with in_valid dropping between bytes.
        gen_random(DEPTH, 3);
        run_modelled("full32", 1'b1);

        // Random loads, some of them deliberately malformed.
        for (int r = 0; r < 16; r++) begin
            gen_random(0, int'($urandom_range(0, 9)));
            run_modelled($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Boot-time program loader directly upstream of the CPU's 32-entry, 19-bit instruction memory.
- Accepts a byte stream over a valid/ready handshake, assembles 19-bit instruction words, and writes them sequentially into instruction memory.
- Pads unused locations with a fill word.
- Holds the CPU in reset until a complete, well-formed image is loaded, then releases it.

Parameters:
- WORD_W, 19, instruction word width; fixed by the ISA.
- DEPTH, 32, instruction memory entries.
- ADDR_W, 5, instruction memory address width; log2(DEPTH).
- FILL_WORD, 19'h00000, value written to every address not covered by the image.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- load_req  input  1  single-cycle pulse; starts a new load from IDLE, RUN or ERROR.
- in_valid  input  1  upstream byte valid.
- in_data  input  8  upstream byte.
- in_ready  output  1  loader accepts a byte this cycle; a byte transfers when in_valid && in_ready.
- imem_we  output  1  instruction memory write enable.
- imem_addr  output  ADDR_W  instruction memory write address.
- imem_wdata  output  WORD_W  instruction memory write data.
- cpu_reset  output  1  active-high reset to the CPU; high whenever the CPU must not execute.
- load_done  output  1  high in RUN.
- load_err  output  1  high in ERROR.
- words_loaded  output  ADDR_W+1  count of image words written in the current or last load.

Behaviour:
- Reset (reset low, asynchronous) forces the following values:
  - state = IDLE, cpu_reset = 1, in_ready = 0, imem_we = 0.
  - imem_addr = 0, imem_wdata = 0, load_done = 0, load_err = 0, words_loaded = 0.
- All outputs are registered. No combinational path from inputs to outputs.
- Stream format:
  - Byte 0 is the word count N, valid range 1..DEPTH.
  - Then 3 bytes per word, big-endian: hi byte bits[2:0] -> word[18:16], mid -> word[15:8], lo -> word[7:0].
  - Hi byte bits[7:3] must be 0.
- IDLE: in_ready = 0, cpu_reset = 1. On load_req, go to COUNT.
- COUNT:
  - in_ready = 1.
  - On transfer with N = 0 or N > DEPTH, go to ERROR.
  - Otherwise latch N, clear the address, clear words_loaded, go to HI.
- HI:
  - On transfer with bits[7:3] != 0, go to ERROR.
  - Otherwise latch bits[2:0], go to MID.
- MID: latch the byte, go to LO.
- LO:
  - Latch the byte.
  - On the next cycle: imem_we = 1 for exactly one cycle with the assembled word at the current address; the address increments; words_loaded increments.
  - in_ready is 0 during that write cycle.
  - If words_loaded reaches N, go to FILL (or CHECK when the optional feature is enabled). Otherwise go to HI.
- in_valid low in any byte state: hold state. No timeout.
- FILL:
  - One write per cycle of FILL_WORD at addresses N..DEPTH-1; in_ready = 0.
  - When N = DEPTH, FILL lasts zero cycles and goes straight to RUN.
  - The address must not wrap past DEPTH-1.
- RUN: cpu_reset = 0 (deasserted the cycle after the last write), load_done = 1, in_ready = 0.
- ERROR:
  - cpu_reset = 1, load_err = 1, in_ready = 0, no further writes.
  - Memory contents are left partial.
- load_req is honoured only in IDLE, RUN and ERROR, and is ignored while a load is in progress.
  - Honoured from RUN: cpu_reset reasserts in the same cycle COUNT is entered.
  - Honoured from RUN or ERROR: load_done and load_err clear.
- A load_req that coincides with an asynchronous reset is lost; the block sits in IDLE.
- Reset mid-load returns the block to IDLE. Memory contents are undefined, and cpu_reset stays 1.

Optional Feature:
- Macro: INSTR_LOADER_CHECKSUM_EN.
- When defined:
  - After the N-th word, enter state CHECK, in_ready = 1, and accept one byte.
  - That byte must equal the XOR of all 3N payload bytes (the count byte is excluded).
  - Match: go to FILL.
  - Mismatch: go to ERROR. Already-written words remain, and cpu_reset stays 1.
- When undefined: CHECK does not exist, and the stream ends at the last lo byte.

Test Plan:
- Reset low mid-stream -> cpu_reset = 1, imem_we = 0, in_ready = 0, load_done = 0 immediately; state IDLE after release.
- load_req, stream 02 | 01 23 45 | 06 78 9A -> writes:
  - addr0 = 19'h12345, addr1 = 19'h6789A;
  - then FILL_WORD written to addresses 2..31 (30 writes);
  - then load_done = 1, cpu_reset = 0, words_loaded = 2.
- Count byte 0x00, and separately 0x21 -> load_err = 1, no imem_we pulses, cpu_reset = 1.
- Hi byte 0x08 in word 0 -> ERROR; no write to addr0.
- in_valid toggling 1/0 every cycle during a 32-word load -> identical memory image; zero fill writes; imem_addr never exceeds 31.
- INSTR_LOADER_CHECKSUM_EN, stream 01 | 00 00 0F | checksum:
  - checksum 0x0F -> RUN;
  - checksum 0x0E -> load_err = 1 and cpu_reset = 1 after addr0 is written.
